// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encoding, IR capture constant
// and elaboration-time opcode helpers.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  localparam logic [1:0] IrCapture = 2'b01;
  localparam int unsigned MaxChannels = 32;

  // ops holds one 32-bit opcode per slot, slot 0 at the LSBs
  function automatic bit opcodes_unique(
    input logic [MaxChannels*32-1:0] ops,
    input int unsigned n
  );
    bit ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = i + 1; j < n; j++) begin
        if (ops[i*32 +: 32] == ops[j*32 +: 32]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/jtag_tap_multi_if.sv
// jtag_tap_multi_if: TAP state and DR strobe bundle
// published by the TAP state machine.
interface jtag_tap_multi_if;
  logic [3:0] state;
  logic       tlr;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;

  modport master (
    output state, tlr,
    output capture_dr, shift_dr, update_dr
  );
  modport slave (
    input state, tlr,
    input capture_dr, shift_dr, update_dr
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller with
// combinational strobe and Test-Logic-Reset decode.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             tms_i,
  output tap_state_e       state_nxt_o,
  jtag_tap_multi_if.master tap
);

  tap_state_e state_d, state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
    endcase
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) state_q <= TestLogicReset;
    else        state_q <= state_d;
  end

  assign state_nxt_o    = trst_i ? TestLogicReset : state_d;
  assign tap.state      = state_q;
  assign tap.tlr        = state_q == TestLogicReset;
  assign tap.capture_dr = state_q == CaptureDr;
  assign tap.shift_dr   = state_q == ShiftDr;
  assign tap.update_dr  = state_q == UpdateDr;

endmodule

// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: TAP with IR, BYPASS, optional IDCODE
// (JTAG_TAP_IDCODE_EN) and N opcode-selected user DRs.
module jtag_tap_multi
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter int unsigned NumChannels = 2,
  parameter logic [31:0] ChannelOpcodes [NumChannels] =
    '{32'h11, 32'h10},
  parameter logic [31:0] IdcodeOpcode = 32'h01,
  parameter logic [31:0] IdcodeValue  = 32'h00000001,
  parameter int unsigned RtiCntWidth  = 8
) (
  input  logic                   tck_i,
  input  logic                   trst_i,
  input  logic                   tms_i,
  input  logic                   td_i,
  output logic                   td_o,
  output logic                   tdo_oe_o,
  output logic [3:0]             tap_state_o,
  output logic                   tlr_o,
  output logic                   capture_dr_o,
  output logic                   shift_dr_o,
  output logic                   update_dr_o,
  output logic [NumChannels-1:0] sel_o,
  input  logic [NumChannels-1:0] ch_tdo_i,
  output logic [IrLength-1:0]    ir_o,
  output logic [RtiCntWidth-1:0] rti_cnt_o
);

  typedef logic [IrLength-1:0] ir_t;
  localparam ir_t IrBypass = '1;
`ifdef JTAG_TAP_IDCODE_EN
  localparam ir_t IrReset = ir_t'(IdcodeOpcode);
`else
  localparam ir_t IrReset = IrBypass;
`endif

  function automatic logic [MaxChannels*32-1:0] flat_ops();
    logic [MaxChannels*32-1:0] f;
    f = '0;
    for (int unsigned k = 0; k < NumChannels && k < MaxChannels; k++)
      f[k*32 +: 32] = ChannelOpcodes[k];
    return f;
  endfunction

  if (IrLength < 2) begin : g_err_irlen
    $error("IrLength must be at least 2");
  end
  if (NumChannels < 1 || NumChannels > MaxChannels) begin : g_err_nch
    $error("NumChannels out of range");
  end
  if (!opcodes_unique(flat_ops(), NumChannels)) begin : g_err_dup
    $error("duplicate ChannelOpcodes");
  end
  if (IdcodeValue[0] == 1'b0) begin : g_err_idv
    $error("IdcodeValue bit 0 must be 1");
  end
  if ((IdcodeOpcode >> IrLength) != 0) begin : g_err_idop
    $error("IdcodeOpcode wider than IrLength");
  end
  for (genvar k = 0; k < NumChannels; k++) begin : g_chk
    if (ChannelOpcodes[k] == IdcodeOpcode ||
        ChannelOpcodes[k] == 32'(IrBypass) ||
        (ChannelOpcodes[k] >> IrLength) != 0) begin : g_err
      $error("illegal channel opcode");
    end
  end

  jtag_tap_multi_if tap ();
  tap_state_e st, st_nxt;

  jtag_tap_fsm u_fsm (
    .tck_i       (tck_i),
    .trst_i      (trst_i),
    .tms_i       (tms_i),
    .state_nxt_o (st_nxt),
    .tap         (tap)
  );

  assign st = tap_state_e'(tap.state);

  ir_t ir_d, ir_q, irs_d, irs_q;
  logic byp_d, byp_q;
  logic [RtiCntWidth-1:0] rti_d, rti_q;
  logic [NumChannels-1:0] sel;
  logic idc_sel, idc_bit, byp_sel, dr_bit;

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NumChannels; k++)
      sel[k] = ir_q == ir_t'(ChannelOpcodes[k]);
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idc_d, idc_q;
  assign idc_sel = ir_q == ir_t'(IdcodeOpcode);
  assign idc_bit = idc_q[0];

  always_comb begin
    idc_d = idc_q;
    if (st == TestLogicReset)
      idc_d = IdcodeValue;
    else if (idc_sel && st == CaptureDr)
      idc_d = IdcodeValue;
    else if (idc_sel && st == ShiftDr)
      idc_d = {td_i, idc_q[31:1]};
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) idc_q <= IdcodeValue;
    else        idc_q <= idc_d;
  end
`else
  assign idc_sel = 1'b0;
  assign idc_bit = 1'b0;
`endif

  assign byp_sel = ~|sel && !idc_sel;

  always_comb begin
    ir_d  = ir_q;
    irs_d = irs_q;
    byp_d = byp_q;
    unique case (1'b1)
      st == TestLogicReset: begin
        ir_d  = IrReset;
        irs_d = '0;
        byp_d = 1'b0;
      end
      st == CaptureIr: irs_d = ir_t'(IrCapture);
      st == ShiftIr:   irs_d = {td_i, irs_q[IrLength-1:1]};
      st == UpdateIr:  ir_d  = irs_q;
      st == CaptureDr: if (byp_sel) byp_d = 1'b0;
      st == ShiftDr:   if (byp_sel) byp_d = td_i;
      default: ;
    endcase
    // counts the cycle being entered, so SelectDrScan already reads 0
    rti_d = '0;
    if (st_nxt == RunTestIdle && st != TestLogicReset)
      rti_d = (&rti_q) ? rti_q : rti_q + RtiCntWidth'(1);
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      ir_q  <= IrReset;
      irs_q <= '0;
      byp_q <= 1'b0;
      rti_q <= '0;
    end else begin
      ir_q  <= ir_d;
      irs_q <= irs_d;
      byp_q <= byp_d;
      rti_q <= rti_d;
    end
  end

  always_comb begin
    dr_bit = byp_q;
    if (idc_sel) dr_bit = idc_bit;
    for (int unsigned k = 0; k < NumChannels; k++)
      if (sel[k]) dr_bit = ch_tdo_i[k];
  end

  assign tdo_oe_o     = st == ShiftIr || st == ShiftDr;
  assign td_o         = tdo_oe_o &
                        (st == ShiftIr ? irs_q[0] : dr_bit);
  assign tap_state_o  = tap.state;
  assign tlr_o        = tap.tlr;
  assign capture_dr_o = tap.capture_dr;
  assign shift_dr_o   = tap.shift_dr;
  assign update_dr_o  = tap.update_dr;
  assign sel_o        = sel;
  assign ir_o         = ir_q;
  assign rti_cnt_o    = rti_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// tb_jtag_tap_multi: randomized scoreboard bench for
// jtag_tap_multi against a queue-based TAP model.
module tb_jtag_tap_multi;

  localparam int IrLen = 5;
  localparam logic [4:0] Ch0  = 5'h11;
  localparam logic [4:0] Ch1  = 5'h10;
  localparam logic [4:0] IdOp = 5'h01;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [31:0] IdVal = 32'h00000001;
  localparam logic [4:0]  IrRst = IdOp;
`else
  localparam logic [4:0]  IrRst = 5'h1f;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       tlr;
    logic       cap;
    logic       sh;
    logic       upd;
    logic       oe;
    logic       td;
    logic [1:0] sel;
    logic [4:0] ir;
    logic [7:0] rti;
  } obs_t;

  logic tck = 1'b0;
  logic trst = 1'b1;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic [1:0] ch_tdo = 2'b00;
  logic td, oe;
  logic [1:0] sel;
  logic [4:0] ir;
  logic [7:0] rti;

  jtag_tap_multi_if mon ();

  always #5 tck = ~tck;

  jtag_tap_multi dut (
    .tck_i        (tck),
    .trst_i       (trst),
    .tms_i        (tms),
    .td_i         (tdi),
    .td_o         (td),
    .tdo_oe_o     (oe),
    .tap_state_o  (mon.state),
    .tlr_o        (mon.tlr),
    .capture_dr_o (mon.capture_dr),
    .shift_dr_o   (mon.shift_dr),
    .update_dr_o  (mon.update_dr),
    .sel_o        (sel),
    .ch_tdo_i     (ch_tdo),
    .ir_o         (ir),
    .rti_cnt_o    (rti)
  );

  int tests = 0;
  int fails = 0;
  obs_t exp_q[$];

  // reference model: state index in standard order
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int         m_st  = 0;
  logic [4:0] m_ir  = IrRst;
  logic [7:0] m_rti = '0;
  bit         m_irq[$];
  bit         m_dr[$];

  function automatic logic [1:0] m_sel();
    return {m_ir == Ch1, m_ir == Ch0};
  endfunction

  function automatic bit m_idc();
`ifdef JTAG_TAP_IDCODE_EN
    return m_ir == IdOp;
`else
    return 1'b0;
`endif
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("st=%0d tlr=%b cap=%b sh=%b upd=%b oe=%b td=%b sel=%b ir=%h rti=%0d",
      o.st, o.tlr, o.cap, o.sh, o.upd, o.oe, o.td, o.sel, o.ir, o.rti);
  endfunction

  task automatic drive(input bit t_tms, input bit t_tdi, input bit t_rst = 1'b0);
    obs_t e;
    int nst;
    @(negedge tck);
    tms = t_tms;
    tdi = t_tdi;
    trst = t_rst;
    ch_tdo = 2'($urandom);
    e = '0;
    e.st  = 4'(m_st);
    e.tlr = m_st == 0;
    e.cap = m_st == 3;
    e.sh  = m_st == 4;
    e.upd = m_st == 8;
    e.oe  = m_st == 4 || m_st == 11;
    e.sel = m_sel();
    e.ir  = m_ir;
    e.rti = m_rti;
    if (m_st == 11) e.td = m_irq[0];
    else if (m_st == 4) begin
      if (e.sel[0])      e.td = ch_tdo[0];
      else if (e.sel[1]) e.td = ch_tdo[1];
      else               e.td = m_dr[0];
    end
    exp_q.push_back(e);
    nst = t_tms ? nxt1[m_st] : nxt0[m_st];
    if (t_rst || m_st == 0) begin
      m_ir = IrRst;
      m_rti = '0;
      m_irq.delete();
      m_dr.delete();
    end else begin
      case (m_st)
        10: begin
          m_irq.delete();
          for (int i = 0; i < IrLen; i++) m_irq.push_back(i == 0);
        end
        11: begin
          void'(m_irq.pop_front());
          m_irq.push_back(t_tdi);
        end
        15: for (int i = 0; i < IrLen; i++) m_ir[i] = m_irq[i];
        3: if (m_sel() == 2'b00) begin
          m_dr.delete();
`ifdef JTAG_TAP_IDCODE_EN
          if (m_idc()) for (int i = 0; i < 32; i++) m_dr.push_back(IdVal[i]);
          else m_dr.push_back(1'b0);
`else
          m_dr.push_back(1'b0);
`endif
        end
        4: if (m_sel() == 2'b00) begin
          void'(m_dr.pop_front());
          m_dr.push_back(t_tdi);
        end
        default: ;
      endcase
      m_rti = (nst == 1) ? ((m_rti == 8'hff) ? m_rti : m_rti + 8'd1) : 8'd0;
    end
    m_st = t_rst ? 0 : nst;
  endtask

  task automatic go_tlr();
    repeat (5) drive(1'b1, 1'($urandom));
  endtask

  task automatic ir_to_exit1(input logic [4:0] op);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < IrLen; i++) drive(i == IrLen - 1, op[i]);
  endtask

  task automatic ir_scan(input logic [4:0] op);
    ir_to_exit1(op);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] data);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive(i == n - 1, data[i]);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge tck);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st  = mon.state;
        a.tlr = mon.tlr;
        a.cap = mon.capture_dr;
        a.sh  = mon.shift_dr;
        a.upd = mon.update_dr;
        a.oe  = oe;
        a.td  = td;
        a.sel = sel;
        a.ir  = ir;
        a.rti = rti;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL obs @%0t got {%s} expected {%s}", $time, fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin
    logic [4:0] ops [6];
    logic [63:0] rnd;
    ops = '{Ch0, Ch1, IdOp, 5'h1f, 5'h00, 5'h07};
    @(posedge tck);
    // IDCODE (or bypass) scan straight out of reset
    drive(1'b0, 1'b0, 1'b0);
    dr_scan(32, 64'h0);
    // five TMS=1 from ShiftDr, UpdateIr and PauseIr
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'($urandom));
    go_tlr();
    drive(1'b0, 1'b0);
    ir_to_exit1(Ch1);
    drive(1'b1, 1'b0);
    go_tlr();
    drive(1'b0, 1'b0);
    ir_to_exit1(5'h07);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    go_tlr();
    drive(1'b0, 1'b0);
    // channel 1 echo, then bypass delay
    ir_scan(Ch1);
    rnd = {$urandom, $urandom};
    dr_scan(16, rnd);
    ir_scan(5'h07);
    dr_scan(4, 64'b1101);
    // Run-Test/Idle saturation
    repeat (300) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    go_tlr();
    drive(1'b0, 1'b0);
    // trst mid-scan on channel 0
    ir_scan(Ch0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'($urandom));
    drive(1'b0, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0);
    // random IR/DR scans
    for (int k = 0; k < 10; k++) begin
      rnd = {$urandom, $urandom};
      ir_scan(ops[$urandom_range(0, 5)]);
      dr_scan($urandom_range(1, 40), rnd);
    end
    // fully random pin activity
    for (int k = 0; k < 600; k++)
      drive(1'($urandom), 1'($urandom), $urandom_range(0, 63) == 0);
    repeat (3) @(negedge tck);
    #4;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_tap_multi.md
# jtag_tap_multi

Parametrised IEEE 1149.1 TAP controller that generalises the single-purpose DMI TAP to an arbitrary number of user data registers selected by configurable opcodes. It owns the TAP state machine, the IR, and the BYPASS and IDCODE registers, and routes capture/shift/update strobes to external DR owners. Typical users are the DTMCS and DMI access registers, plus any extra user DRs such as a JTAG-AXI bridge. It sits directly behind the JTAG pads, in front of the DTM and bridge DR logic.

## Interface
Parameters:
- IrLength, 5, instruction register width (≥ 2)
- NumChannels, 2, number of external user DRs
- ChannelOpcodes, {5'h11, 5'h10}, opcode per channel; index 0 = channel 0
- IdcodeOpcode, 5'h01, opcode selecting IDCODE
- IdcodeValue, 32'h00000001, IDCODE contents; bit 0 must be 1
- RtiCntWidth, 8, width of the Run-Test/Idle cycle counter

Ports:
- tck_i  in  1  JTAG clock; the only clock
- trst_i  in  1  reset, synchronous, active-high
- tms_i  in  1  test mode select
- td_i  in  1  test data in
- td_o  out  1  test data out
- tdo_oe_o  out  1  TDO enable; high in ShiftIr/ShiftDr
- tap_state_o  out  4  current TAP state encoding
- tlr_o  out  1  high while in Test-Logic-Reset
- capture_dr_o / shift_dr_o / update_dr_o  out  1 each  DR strobes, one per state
- sel_o  out  NumChannels  one-hot channel select decoded from the IR
- ch_tdo_i  in  NumChannels  serial out of each channel DR
- ir_o  out  IrLength  current instruction
- rti_cnt_o  out  RtiCntWidth  consecutive cycles spent in Run-Test/Idle

## Operation
- FSM has 16 standard states, TestLogicReset through UpdateIr, with standard TMS transitions. All registers update on the rising edge of tck_i.
- When trst_i is sampled high:
  - state = TestLogicReset, IR = IdcodeOpcode, IR shift = 0, bypass = 0, idcode shift = IdcodeValue, rti counter = 0.
  - Outputs: tlr_o = 1, all strobes = 0, tdo_oe_o = 0, td_o = 0.
- TestLogicReset state applies the same register values as trst_i every cycle it is occupied.
- CaptureIr loads the IR shift register with {(IrLength-2)'0, 2'b01}.
- ShiftIr shifts right with td_i entering at the MSB.
- UpdateIr copies the IR shift register to the IR.
- Decode:
  - IR == ChannelOpcodes[k] → sel_o[k] = 1.
  - IR == IdcodeOpcode → IDCODE.
  - Anything else, including all-ones and all-zeros → BYPASS, with sel_o = 0.
- CaptureDr:
  - IDCODE selected: idcode shift ← IdcodeValue.
  - BYPASS selected: bypass ← 0.
  - Channel selected: only the strobe is emitted.
- ShiftDr: the selected internal register shifts right, td_i in at the MSB. BYPASS takes td_i directly.
- td_o selection:
  - ShiftIr → IR shift[0].
  - Otherwise, by decode: ch_tdo_i[k], idcode[0], or bypass.
  - td_o is driven 0 when tdo_oe_o = 0.
- td_o and tdo_oe_o are combinational from registered state. Falling-edge retiming is done in the pad ring, outside this block.
- RTI counter:
  - Increments each cycle the FSM is in RunTestIdle.
  - Saturates at all-ones.
  - Clears to 0 on any cycle in any other state.
- Elaboration-time errors:
  - duplicate ChannelOpcodes;
  - a channel opcode equal to IdcodeOpcode or all-ones;
  - an opcode wider than IrLength;
  - IdcodeValue[0] = 0.

## Timing
- Strobes are combinational decodes of the current state. Each is high for exactly the cycles spent in its state.
- A new IR takes effect on the first rising edge after UpdateIr: sel_o changes on the edge that leaves UpdateIr.
- A channel's first shifted bit appears on td_o in the first ShiftDr cycle. The channel presents ch_tdo_i from its capture value.
- From any state, 5 consecutive TMS=1 edges reach TestLogicReset.
- If trst_i is asserted mid-ShiftDr or mid-ShiftIr, the scan is abandoned and no update strobe is issued. trst_i overrides TMS on the same edge.
- Pause and Exit2 states hold every register unchanged.

## Configuration
- JTAG_TAP_IDCODE_EN defined: IDCODE register present; reset IR = IdcodeOpcode.
- JTAG_TAP_IDCODE_EN undefined:
  - No IDCODE register.
  - IdcodeOpcode decodes as BYPASS.
  - Reset IR = all-ones (BYPASS), so td_o shifts 0 after CaptureDr.

## Structure
- jtag_tap_pkg holds:
  - tap_state_e, the 4-bit state enum in standard order;
  - the IR capture constant 2'b01;
  - a function checking opcode uniqueness.
- Sub-module jtag_tap_fsm contains the state register, next-state logic, and the strobe/tlr decode. It is reusable by future multi-TAP chains.

## Test plan
- Reset, then DR scan of 32 bits with td_i=0 → td_o sequence LSB-first equals 32'h00000001. With the macro off → 32 zero bits.
- Hold TMS=1 for 5 cycles from ShiftDr, UpdateIr, and PauseIr → tap_state_o = TestLogicReset, tlr_o = 1, ir_o = IdcodeOpcode.
- IR scan shifting in 5'h10 → the captured 5'b00001 appears on td_o LSB-first; after UpdateIr, sel_o = 2'b10. A DR scan then echoes ch_tdo_i[1] on td_o.
- IR scan shifting in 5'h07 → sel_o = 0. A DR scan of pattern 1,0,1,1 with td_i yields td_o 0,1,0,1 (one-bit bypass delay).
- Hold RunTestIdle for 300 cycles with RtiCntWidth=8 → rti_cnt_o reads 1..255 and holds 255. On TMS=1 it reads 0 in SelectDrScan.
- Assert trst_i for 1 cycle in the middle of a 20-bit ShiftDr on channel 0 → next cycle TestLogicReset, update_dr_o never pulses, sel_o = 0.
